// File: rtl/rom_dl_router.sv
// rom_dl_router
//   ROM download router and boot sequencer for the Irem M62 top level.
//   Decodes hps_io ioctl writes by index and address window and forwards ROM
//   bytes to NUM_PORTS SDRAM write ports using toggle request/acknowledge
//   handshakes. Also captures DIP switch bytes and core_mod, and stretches
//   the core reset until a ROM image has been loaded.
//
//   Optional feature: define ROM_DL_CHECKSUM_EN to accumulate a 16-bit
//   wrap-around sum of every ROM byte on dl_sum (cleared when a ROM download
//   starts). Without it dl_sum is tied to zero.
//
// Ports
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ioctl_*        hps_io download bus (wr is a level, edge-detected here)
//   soft_reset     user reset request (status[0] | buttons[1])
//   port_ack/req   per-port toggle handshake with the sdram controller
//   port_a/ds      per-port word address and byte strobes
//   port_d         write data {byte, byte}, shared by all ports
//   port_we        ROM download active
//   dip_sw         captured DIP bytes, byte k at [8k+7:8k]
//   core_mod       hardware-variant select byte
//   rom_loaded     sticky, set when a ROM download ends
//   core_reset     active-high reset to target_top
//   overrun        sticky, ROM write hit a port whose request was pending
//   dl_sum         ROM checksum (zero unless ROM_DL_CHECKSUM_EN)

module rom_dl_router #(
    parameter int unsigned               NUM_PORTS  = 2,
    parameter logic [NUM_PORTS*25-1:0]   PORT_BASE  = {25'h30000, 25'h0},
    parameter logic [NUM_PORTS*25-1:0]   PORT_LIMIT = {25'hA0000, 25'h30000},
    parameter logic [7:0]                ROM_INDEX  = 8'd0,
    parameter logic [7:0]                MOD_INDEX  = 8'd1,
    parameter logic [7:0]                DIP_INDEX  = 8'd254,
    parameter int unsigned               DIP_BYTES  = 8,
    parameter logic [15:0]               RESET_HOLD = 16'hFFFF
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      ioctl_download,
    input  logic [7:0]                ioctl_index,
    input  logic                      ioctl_wr,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    input  logic                      soft_reset,
    input  logic [NUM_PORTS-1:0]      port_ack,
    output logic [NUM_PORTS-1:0]      port_req,
    output logic [NUM_PORTS*23-1:0]   port_a,
    output logic [NUM_PORTS*2-1:0]    port_ds,
    output logic [15:0]               port_d,
    output logic                      port_we,
    output logic [8*DIP_BYTES-1:0]    dip_sw,
    output logic [7:0]                core_mod,
    output logic                      rom_loaded,
    output logic                      core_reset,
    output logic                      overrun,
    output logic [15:0]               dl_sum
);

    logic                     r_wr_last;
    logic                     r_rom_dl_last;
    logic [NUM_PORTS-1:0]     r_port_req;
    logic [NUM_PORTS*23-1:0]  r_port_a;
    logic [NUM_PORTS*2-1:0]   r_port_ds;
    logic [15:0]              r_port_d;
    logic [8*DIP_BYTES-1:0]   r_dip;
    logic [7:0]               r_core_mod;
    logic                     r_rom_loaded;
    logic                     r_overrun;
    logic [15:0]              r_cnt;
    logic                     r_core_reset;

    logic                     w_rom_dl;
    logic                     w_wr_evt;
    logic                     w_rom_evt;
    logic                     w_mod_evt;
    logic                     w_dip_evt;
    logic [NUM_PORTS-1:0]     w_hit;
    logic [NUM_PORTS-1:0]     w_pend;
    logic [23:0]              w_off [NUM_PORTS];

    assign w_rom_dl  = ioctl_download & (ioctl_index == ROM_INDEX);
    assign w_wr_evt  = ioctl_wr & ~r_wr_last;
    assign w_rom_evt = w_wr_evt & w_rom_dl;
    assign w_mod_evt = w_wr_evt & (ioctl_index == MOD_INDEX);
    assign w_dip_evt = w_wr_evt & (ioctl_index == DIP_INDEX) &
                       (ioctl_addr[24:3] == '0) &
                       (32'(ioctl_addr[2:0]) < DIP_BYTES);
    assign w_pend    = r_port_req ^ port_ack;

    // Offset bits above 23 never reach port_a, so only the low 24 bits of
    // the subtraction are formed; the window compare uses the full address.
    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_hit[i] = (ioctl_addr >= PORT_BASE[i*25 +: 25]) &&
                       (ioctl_addr <  PORT_LIMIT[i*25 +: 25]);
            w_off[i] = ioctl_addr[23:0] - PORT_BASE[i*25 +: 24];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_last     <= 1'b0;
            r_rom_dl_last <= 1'b0;
            r_port_req    <= '0;
            r_port_a      <= '0;
            r_port_ds     <= '0;
            r_port_d      <= '0;
            r_dip         <= '0;
            r_core_mod    <= '0;
            r_rom_loaded  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_wr_last     <= ioctl_wr;
            r_rom_dl_last <= w_rom_dl;
            if (w_rom_evt) begin
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (w_hit[i]) begin
                        r_port_req[i]         <= ~r_port_req[i];
                        r_port_a[i*23 +: 23]  <= w_off[i][23:1];
                        r_port_ds[i*2 +: 2]   <= {w_off[i][0], ~w_off[i][0]};
                    end
                end
                if (|w_hit)
                    r_port_d <= {ioctl_dout, ioctl_dout};
                if (|(w_hit & w_pend))
                    r_overrun <= 1'b1;
            end
            if (w_mod_evt)
                r_core_mod <= ioctl_dout;
            if (w_dip_evt) begin
                for (int unsigned k = 0; k < DIP_BYTES; k++) begin
                    if (ioctl_addr[2:0] == 3'(k))
                        r_dip[k*8 +: 8] <= ioctl_dout;
                end
            end
            if (r_rom_dl_last & ~w_rom_dl)
                r_rom_loaded <= 1'b1;
        end
    end

    // Reset stretch: the load term sees the old rom_loaded, so the edge that
    // sets rom_loaded is the last load cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= RESET_HOLD;
            r_core_reset <= 1'b1;
        end else begin
            if (soft_reset | ~r_rom_loaded | w_rom_dl)
                r_cnt <= RESET_HOLD;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 16'd1;
            r_core_reset <= (r_cnt != '0);
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] r_sum;
    logic        w_rom_rise;

    assign w_rom_rise = w_rom_dl & ~r_rom_dl_last;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_sum <= '0;
        else if (w_rom_rise)
            r_sum <= w_rom_evt ? {8'h00, ioctl_dout} : '0;
        else if (w_rom_evt)
            r_sum <= r_sum + {8'h00, ioctl_dout};
    end

    assign dl_sum = r_sum;
`else
    assign dl_sum = '0;
`endif

    assign port_req   = r_port_req;
    assign port_a     = r_port_a;
    assign port_ds    = r_port_ds;
    assign port_d     = r_port_d;
    assign port_we    = w_rom_dl;
    assign dip_sw     = r_dip;
    assign core_mod   = r_core_mod;
    assign rom_loaded = r_rom_loaded;
    assign core_reset = r_core_reset;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_rom_dl_router.sv
module tb_rom_dl_router;

    logic         clk_sys = 1'b0;
    logic         reset_n;
    logic         ioctl_download;
    logic [7:0]   ioctl_index;
    logic         ioctl_wr;
    logic [24:0]  ioctl_addr;
    logic [7:0]   ioctl_dout;
    logic         soft_reset;
    logic [1:0]   port_ack;
    logic [1:0]   port_req;
    logic [45:0]  port_a;
    logic [3:0]   port_ds;
    logic [15:0]  port_d;
    logic         port_we;
    logic [63:0]  dip_sw;
    logic [7:0]   core_mod;
    logic         rom_loaded;
    logic         core_reset;
    logic         overrun;
    logic [15:0]  dl_sum;

`ifdef ROM_DL_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    // Port 0 window widened so the two windows overlap above 0x30000.
    rom_dl_router #(
        .NUM_PORTS  (2),
        .PORT_BASE  ({25'h30000, 25'h0}),
        .PORT_LIMIT ({25'hA0000, 25'hA0000}),
        .ROM_INDEX  (8'd0),
        .MOD_INDEX  (8'd1),
        .DIP_INDEX  (8'd254),
        .DIP_BYTES  (8),
        .RESET_HOLD (16'd16)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .soft_reset     (soft_reset),
        .port_ack       (port_ack),
        .port_req       (port_req),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .port_we        (port_we),
        .dip_sw         (dip_sw),
        .core_mod       (core_mod),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset),
        .overrun        (overrun),
        .dl_sum         (dl_sum)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]  idx;
        logic        dl;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        ack;
        logic [1:0]  req;
        logic [45:0] a;
        logic [3:0]  ds;
        logic [15:0] d;
        logic        ovr;
        logic [63:0] dip;
        logic [7:0]  mod;
    } vec_t;

    vec_t        vt [13];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_sum = '0;
    int unsigned n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // wr held for three cycles: must still count as a single event.
    task automatic do_write(input logic [7:0] idx, input logic dl,
                            input logic [24:0] addr, input logic [7:0] data);
        @(posedge clk_sys); #1;
        ioctl_index    = idx;
        ioctl_download = dl;
        ioctl_addr     = addr;
        ioctl_dout     = data;
        ioctl_wr       = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 ioctl_wr = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    initial begin
        //        idx    dl    addr        data   ack   req    {a1, a0}                  ds       d         ovr   dip                    mod
        vt[0]  = '{8'd0,   1'b1, 25'h00001, 8'h5A, 1'b1, 2'b01, {23'd0, 23'd0},         4'b0010, 16'h5A5A, 1'b0, 64'h0,                 8'h00};
        vt[1]  = '{8'd0,   1'b1, 25'h30004, 8'h3C, 1'b1, 2'b10, {23'd2, 23'h18002},     4'b0101, 16'h3C3C, 1'b0, 64'h0,                 8'h00};
        vt[2]  = '{8'd0,   1'b1, 25'hA0000, 8'h77, 1'b1, 2'b10, {23'd2, 23'h18002},     4'b0101, 16'h3C3C, 1'b0, 64'h0,                 8'h00};
        vt[3]  = '{8'd0,   1'b1, 25'h2FFFF, 8'h11, 1'b1, 2'b11, {23'd2, 23'h17FFF},     4'b0110, 16'h1111, 1'b0, 64'h0,                 8'h00};
        vt[4]  = '{8'd0,   1'b1, 25'h30000, 8'h22, 1'b1, 2'b00, {23'd0, 23'h18000},     4'b0101, 16'h2222, 1'b0, 64'h0,                 8'h00};
        vt[5]  = '{8'd0,   1'b1, 25'h00002, 8'h01, 1'b0, 2'b01, {23'd0, 23'd1},         4'b0101, 16'h0101, 1'b0, 64'h0,                 8'h00};
        vt[6]  = '{8'd0,   1'b1, 25'h00003, 8'h02, 1'b1, 2'b00, {23'd0, 23'd1},         4'b0110, 16'h0202, 1'b1, 64'h0,                 8'h00};
        vt[7]  = '{8'd0,   1'b1, 25'h00004, 8'h03, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'h0,                 8'h00};
        vt[8]  = '{8'd254, 1'b1, 25'h00003, 8'hC4, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'h00000000C4000000, 8'h00};
        vt[9]  = '{8'd254, 1'b1, 25'h00009, 8'hFF, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'h00000000C4000000, 8'h00};
        vt[10] = '{8'd254, 1'b1, 25'h00000, 8'h81, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'h00000000C4000081, 8'h00};
        vt[11] = '{8'd254, 1'b1, 25'h00007, 8'hEE, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'hEE000000C4000081, 8'h00};
        vt[12] = '{8'd1,   1'b0, 25'h00123, 8'hA5, 1'b1, 2'b01, {23'd0, 23'd2},         4'b0101, 16'h0303, 1'b1, 64'hEE000000C4000081, 8'hA5};

        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; soft_reset = 1'b0; port_ack = 2'b00;
        repeat (3) @(posedge clk_sys); #1;

        chk("rst_req", 64'(port_req), 64'h0);
        chk("rst_a", 64'(port_a), 64'h0);
        chk("rst_ds", 64'(port_ds), 64'h0);
        chk("rst_d", 64'(port_d), 64'h0);
        chk("rst_dip", dip_sw, 64'h0);
        chk("rst_mod", 64'(core_mod), 64'h0);
        chk("rst_loaded", 64'(rom_loaded), 64'h0);
        chk("rst_core_reset", 64'(core_reset), 64'h1);
        chk("rst_overrun", 64'(overrun), 64'h0);
        chk("rst_sum", 64'(dl_sum), 64'h0);

        reset_n = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys); #1;
        chk("port_we", 64'(port_we), 64'h1);

        for (int i = 0; i < 8; i++) begin
            do_write(vt[i].idx, vt[i].dl, vt[i].addr, vt[i].data);
            if (vt[i].dl && vt[i].idx == 8'd0) exp_sum = exp_sum + {8'h00, vt[i].data};
            chk($sformatf("v%0d_req", i), 64'(port_req), 64'(vt[i].req));
            chk($sformatf("v%0d_a", i), 64'(port_a), 64'(vt[i].a));
            chk($sformatf("v%0d_ds", i), 64'(port_ds), 64'(vt[i].ds));
            chk($sformatf("v%0d_d", i), 64'(port_d), 64'(vt[i].d));
            chk($sformatf("v%0d_ovr", i), 64'(overrun), 64'(vt[i].ovr));
            chk($sformatf("v%0d_sum", i), 64'(dl_sum), CSUM ? 64'(exp_sum) : 64'h0);
            if (vt[i].ack) port_ack = vt[i].req;
        end

        chk("dl_core_reset", 64'(core_reset), 64'h1);
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
        chk("end_loaded", 64'(rom_loaded), 64'h1);
        chk("end_core_reset_held", 64'(core_reset), 64'h1);
        n = 0;
        while (core_reset && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("end_release_cycles", 64'(n), 64'd17);

        soft_reset = 1'b1;
        @(posedge clk_sys); #1;
        soft_reset = 1'b0;
        chk("soft_same_cycle", 64'(core_reset), 64'h0);
        @(posedge clk_sys); #1;
        chk("soft_reassert", 64'(core_reset), 64'h1);
        n = 1;
        while (core_reset && n < 40) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk("soft_release_cycles", 64'(n), 64'd17);

        for (int i = 8; i < 13; i++) begin
            do_write(vt[i].idx, vt[i].dl, vt[i].addr, vt[i].data);
            chk($sformatf("v%0d_req", i), 64'(port_req), 64'(vt[i].req));
            chk($sformatf("v%0d_a", i), 64'(port_a), 64'(vt[i].a));
            chk($sformatf("v%0d_ovr", i), 64'(overrun), 64'(vt[i].ovr));
            chk($sformatf("v%0d_dip", i), dip_sw, vt[i].dip);
            chk($sformatf("v%0d_mod", i), 64'(core_mod), 64'(vt[i].mod));
            if (vt[i].ack) port_ack = vt[i].req;
        end
        chk("loaded_kept", 64'(rom_loaded), 64'h1);
        chk("core_reset_idle", 64'(core_reset), 64'h0);

        // Reset in the middle of a ROM download.
        @(posedge clk_sys); #1;
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        repeat (3) @(posedge clk_sys); #1;
        do_write(8'd0, 1'b1, 25'h00010, 8'h55);
        chk("mid_req", 64'(port_req), 64'h0);
        reset_n = 1'b0;
        port_ack = 2'b00;
        #2;
        chk("mid_rst_req", 64'(port_req), 64'h0);
        chk("mid_rst_a", 64'(port_a), 64'h0);
        chk("mid_rst_d", 64'(port_d), 64'h0);
        chk("mid_rst_ovr", 64'(overrun), 64'h0);
        chk("mid_rst_loaded", 64'(rom_loaded), 64'h0);
        chk("mid_rst_core_reset", 64'(core_reset), 64'h1);
        chk("mid_rst_dip", dip_sw, 64'h0);
        chk("mid_rst_mod", 64'(core_mod), 64'h0);
        chk("mid_rst_sum", 64'(dl_sum), 64'h0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys); #1;

        do_write(8'd0, 1'b1, 25'h00000, 8'hFF);
        chk("post_req", 64'(port_req), 64'h1);
        chk("post_ds", 64'(port_ds), 64'h1);
        port_ack = 2'b01;
        do_write(8'd0, 1'b1, 25'h00001, 8'h02);
        port_ack = 2'b00;
        do_write(8'd0, 1'b1, 25'h00002, 8'h10);
        chk("post_req3", 64'(port_req), 64'h1);
        chk("post_a3", 64'(port_a), 64'h1);
        chk("post_ovr", 64'(overrun), 64'h0);
        chk("post_loaded", 64'(rom_loaded), 64'h0);
        chk("post_sum", 64'(dl_sum), CSUM ? 64'h0111 : 64'h0);

        ioctl_download = 1'b0;
        repeat (2) @(posedge clk_sys); #1;
        chk("post_end_loaded", 64'(rom_loaded), 64'h1);
        ioctl_download = 1'b1;
        repeat (2) @(posedge clk_sys); #1;
        chk("restart_sum", 64'(dl_sum), 64'h0);
        chk("restart_core_reset", 64'(core_reset), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
